// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin burst drain of N_SRC source FIFOs into one shared destination FIFO.
// Optional destination write counter enabled by `define FIFO_ARB_XFER_CNT_EN.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant; pick the next eligible source after the pointer
//   XFER  | granted source drained, up to BURST_LEN reads
module fifo_rr_drain_arbiter #(
    parameter int N_SRC      = 4,
    parameter int SEL_W      = 2,
    parameter int RD_LATENCY = 2,
    parameter int BURST_LEN  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] src_almst_empty_i,
    output logic [N_SRC-1:0] src_rd_o,
    input  logic             dst_almst_full_i,
    output logic             dst_wr_o,
    output logic [SEL_W-1:0] dst_sel_o,
    output logic [SEL_W-1:0] grant_o,
    output logic             busy_o,
    output logic [15:0]      xfer_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [7:0]       BURST_MAX = 8'(BURST_LEN);
    localparam logic [N_SRC-1:0] ONE_HOT0  = N_SRC'(1);
    localparam logic [SEL_W-1:0] PTR_RST   = SEL_W'(N_SRC - 1);

    state_t            state;
    logic [SEL_W-1:0]  ptr;
    logic [7:0]        burst_cnt;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic [RD_LATENCY-1:0] wr_pipe;
    logic [SEL_W-1:0]  sel_pipe [RD_LATENCY];

    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int off);
        return SEL_W'((int'(base) + off) % N_SRC);
    endfunction

    // First eligible source strictly after the pointer, wrapping back to the pointer itself last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!pick_found && !src_almst_empty_i[wrap_idx(ptr, k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(ptr, k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            grant_o   <= '0;
            burst_cnt <= '0;
            busy_o    <= 1'b0;
            src_rd_o  <= '0;
        end else begin
            src_rd_o <= '0;
            case (state)
                IDLE: begin
                    if (!dst_almst_full_i && pick_found) begin
                        grant_o   <= pick_idx;
                        burst_cnt <= '0;
                        busy_o    <= 1'b1;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (src_almst_empty_i[grant_o] || burst_cnt == BURST_MAX) begin
                        ptr    <= grant_o;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (!dst_almst_full_i) begin
                        src_rd_o  <= ONE_HOT0 << grant_o;
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Strobe and select travel together; select only updates on real reads so the
    // mux switches exactly on the first write of a new source.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                sel_pipe[i] <= '0;
            end
        end else begin
            wr_pipe[0] <= |src_rd_o;
            if (|src_rd_o) begin
                sel_pipe[0] <= grant_o;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                wr_pipe[i]  <= wr_pipe[i-1];
                sel_pipe[i] <= sel_pipe[i-1];
            end
        end
    end

    assign dst_wr_o  = wr_pipe[RD_LATENCY-1];
    assign dst_sel_o = sel_pipe[RD_LATENCY-1];

`ifdef FIFO_ARB_XFER_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xfer_cnt_o <= '0;
        end else if (dst_wr_o && xfer_cnt_o != 16'hFFFF) begin
            xfer_cnt_o <= xfer_cnt_o + 16'd1;
        end
    end
`else
    assign xfer_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Directed bench for fifo_rr_drain_arbiter (N_SRC=4, RD_LATENCY=2, BURST_LEN=4).
// Write-counter expectations follow FIFO_ARB_XFER_CNT_EN.
module tb_fifo_rr_drain_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  src_almst_empty_i = 4'hF;
    logic [3:0]  src_rd_o;
    logic        dst_almst_full_i = 1'b0;
    logic        dst_wr_o;
    logic [1:0]  dst_sel_o;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic [15:0] xfer_cnt_o;

`ifdef FIFO_ARB_XFER_CNT_EN
    localparam int XC16 = 16;
`else
    localparam int XC16 = 0;
`endif

    fifo_rr_drain_arbiter #(
        .N_SRC(4), .SEL_W(2), .RD_LATENCY(2), .BURST_LEN(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .src_almst_empty_i(src_almst_empty_i), .src_rd_o(src_rd_o),
        .dst_almst_full_i(dst_almst_full_i), .dst_wr_o(dst_wr_o),
        .dst_sel_o(dst_sel_o), .grant_o(grant_o), .busy_o(busy_o),
        .xfer_cnt_o(xfer_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail = 0;
    int tick_n = 0;
    int rd_total = 0;
    int wr_total = 0;
    int         rd_t_q [$];
    logic [1:0] rd_g_q [$];

    logic [3:0] rd [32];
    logic       wr [32];
    logic       bz [32];
    logic [1:0] gr [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge. Every read must reappear as a
    // write exactly two cycles later with the grant index it was read under.
    task automatic tick();
        int t;
        logic [1:0] g;
        @(posedge clk_i);
        #1;
        tick_n++;
        if (src_rd_o != 4'b0000) begin
            rd_total++;
            chk("rd_onehot_grant", 32'(src_rd_o), 32'(4'b0001 << grant_o));
            rd_t_q.push_back(tick_n);
            rd_g_q.push_back(grant_o);
        end
        if (dst_wr_o) begin
            wr_total++;
            chk("wr_has_read", 32'(rd_t_q.size() > 0), 1);
            if (rd_t_q.size() > 0) begin
                t = rd_t_q.pop_front();
                g = rd_g_q.pop_front();
                chk("wr_latency", tick_n - t, 2);
                chk("wr_sel", 32'(dst_sel_o), 32'(g));
            end
        end
    endtask

    task automatic sample(input int k);
        tick();
        rd[k] = src_rd_o;
        wr[k] = dst_wr_o;
        bz[k] = busy_o;
        gr[k] = grant_o;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        #12;
        rd_t_q.delete();
        rd_g_q.delete();
        rd_total = 0;
        wr_total = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin : main
        int cnt;
        int bad;
        int n_grant;
        logic prev_busy;
        logic [1:0] g_seq [5];
        int rd_per [5];

        // Reset state and quiet operation with every source almost-empty
        #12;
        chk("rst_src_rd", 32'(src_rd_o), 0);
        chk("rst_dst_wr", 32'(dst_wr_o), 0);
        chk("rst_dst_sel", 32'(dst_sel_o), 0);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_xfer_cnt", 32'(xfer_cnt_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (src_rd_o != 4'b0000 || dst_wr_o || busy_o) bad++;
        end
        chk("t1_quiet_cycles", bad, 0);

        // Only source 2 has data
        src_almst_empty_i = 4'b1011;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            sample(k);
            if (k == 7) src_almst_empty_i = 4'b1111;
        end
        chk("t2_grant", 32'(gr[0]), 2);
        chk("t2_busy", 32'(bz[0]), 1);
        chk("t2_no_rd_on_grant", 32'(rd[0]), 0);
        cnt = 0;
        for (int k = 1; k <= 4; k++) if (rd[k] == 4'b0100) cnt++;
        chk("t2_burst_reads", cnt, 4);
        chk("t2_rd_after_burst", 32'(rd[5]), 0);
        chk("t2_busy_exit", 32'(bz[5]), 0);
        bad = -1;
        for (int k = 0; k < 12; k++) if (wr[k] && bad < 0) bad = k;
        chk("t2_first_wr", bad, 3);
        cnt = 0;
        for (int k = 0; k <= 6; k++) if (wr[k]) cnt++;
        chk("t2_burst_writes", cnt, 4);
        chk("t2_regrant", {29'b0, bz[6], gr[6]}, 32'b110);
        chk("t2_rd_again", 32'(rd[7]), 32'b0100);

        // All sources busy: strict rotation 0,1,2,3,0
        src_almst_empty_i = 4'b0000;
        apply_reset();
        n_grant = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 5; i++) rd_per[i] = 0;
        for (int k = 0; k < 60 && n_grant < 5; k++) begin
            tick();
            if (busy_o && !prev_busy) begin
                g_seq[n_grant] = grant_o;
                n_grant++;
                if (n_grant == 5) src_almst_empty_i = 4'b1111;
            end
            if (src_rd_o != 4'b0000 && n_grant > 0) rd_per[n_grant-1]++;
            prev_busy = busy_o;
        end
        repeat (5) begin
            tick();
            if (src_rd_o != 4'b0000) rd_per[4]++;
        end
        chk("t3_grant_count", n_grant, 5);
        for (int i = 0; i < 5; i++) chk("t3_grant_order", 32'(g_seq[i]), i % 4);
        for (int i = 0; i < 4; i++) chk("t3_reads_per_burst", rd_per[i], 4);
        chk("t3_reads_5th", rd_per[4], 0);
        chk("t3_writes", wr_total, 16);
        chk("t3_xfer_cnt", 32'(xfer_cnt_o), XC16);

        // Destination almost-full pause on source 1
        src_almst_empty_i = 4'b1101;
        apply_reset();
        for (int k = 0; k < 14; k++) begin
            sample(k);
            if (k == 2) dst_almst_full_i = 1'b1;
            if (k == 7) dst_almst_full_i = 1'b0;
            if (k == 9) src_almst_empty_i = 4'b1111;
        end
        chk("t4_grant", 32'(gr[0]), 1);
        chk("t4_rd1", 32'(rd[1]), 32'b0010);
        chk("t4_rd2", 32'(rd[2]), 32'b0010);
        bad = 0;
        for (int k = 3; k <= 7; k++) if (rd[k] != 4'b0000 || !bz[k] || gr[k] != 2'd1) bad++;
        chk("t4_pause_cycles", bad, 0);
        chk("t4_rd3", 32'(rd[8]), 32'b0010);
        chk("t4_rd4", 32'(rd[9]), 32'b0010);
        chk("t4_busy_exit", 32'(bz[10]), 0);
        chk("t4_writes", wr_total, 4);

        // Source 0 empties after its first read; source 1 next
        src_almst_empty_i = 4'b1100;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            sample(k);
            if (k == 1) src_almst_empty_i = 4'b1101;
            if (k == 3) src_almst_empty_i = 4'b1111;
        end
        chk("t5_grant0", 32'(gr[0]), 0);
        chk("t5_rd", 32'(rd[1]), 32'b0001);
        chk("t5_early_exit", {28'b0, bz[2], rd[2][2:0]}, 0);
        chk("t5_next_grant", {29'b0, bz[3], gr[3]}, 32'b101);
        chk("t5_reads", rd_total, 1);
        chk("t5_writes", wr_total, 1);

        // Asynchronous reset with writes in flight
        src_almst_empty_i = 4'b0111;
        apply_reset();
        for (int k = 0; k < 4; k++) sample(k);
        chk("t6_pre_grant", 32'(gr[3]), 3);
        chk("t6_pre_wr", {30'b0, wr[3], bz[3]}, 32'b11);
        chk("t6_pre_sel", 32'(dst_sel_o), 3);
        rst_ni = 1'b0;
        #2;
        chk("t6_async", {src_rd_o, dst_wr_o, dst_sel_o, grant_o, busy_o}, 0);
        chk("t6_async_cnt", 32'(xfer_cnt_o), 0);
        src_almst_empty_i = 4'b1111;
        rd_t_q.delete();
        rd_g_q.delete();
        rd_total = 0;
        wr_total = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        bad = 0;
        repeat (8) begin
            tick();
            if (busy_o) bad++;
        end
        chk("t6_no_wr_after_rst", wr_total, 0);
        chk("t6_no_busy", bad, 0);
        chk("t6_cnt_after_rst", 32'(xfer_cnt_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rr_drain_arbiter.md
Name: fifo_rr_drain_arbiter

Overview:
- Shares one destination FIFO (B) between N_SRC source FIFOs (A0..A(N-1)).
- Selects a source round-robin and issues read strobes in bursts of up to BURST_LEN words.
- Produces a matching write strobe and mux select for the destination, both delayed by the source read latency.
- Sits between the per-lane readout FIFOs and the shared output FIFO. The data mux itself is external and is driven by dst_sel_o.

Parameters:
- N_SRC, 4, number of source FIFOs (2..16)
- SEL_W, 2, width of the select fields; must equal clog2(N_SRC)
- RD_LATENCY, 2, cycles from src_rd_o to valid source data at the mux (1..8)
- BURST_LEN, 16, max reads per grant (1..255)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- src_almst_empty_i  in  N_SRC  per-source almost-empty flag
- src_rd_o  out  N_SRC  per-source read strobe, one-hot or zero
- dst_almst_full_i  in  1  destination almost-full flag
- dst_wr_o  out  1  destination write strobe
- dst_sel_o  out  SEL_W  source index for the data mux, aligned with dst_wr_o
- grant_o  out  SEL_W  currently granted source (valid while busy_o=1)
- busy_o  out  1  high in XFER state
- xfer_cnt_o  out  16  destination write count (see Optional Feature)

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - src_rd_o=0, dst_wr_o=0, dst_sel_o=0, grant_o=0, busy_o=0, xfer_cnt_o=0.
  - Round-robin pointer = N_SRC-1, so source 0 has first priority.
  - FSM=IDLE; delay pipeline cleared.
  - In-flight writes are discarded.
- Eligibility: source i is eligible when src_almst_empty_i[i]=0.
- IDLE:
  - If dst_almst_full_i=0 and any source is eligible, grant the first eligible source searching from pointer+1 upward with wrap, N_SRC-1 -> 0.
  - On grant: latch grant_o, clear burst counter, go to XFER.
  - Never issue a read in IDLE.
- XFER (busy_o=1):
  - Each cycle where src_almst_empty_i[grant]=0, dst_almst_full_i=0 and burst_cnt<BURST_LEN: assert src_rd_o[grant] for 1 cycle and increment burst_cnt.
  - If dst_almst_full_i=1: hold the read low and stay in XFER (pause, no regrant).
  - Exit to IDLE on the cycle after the last read (burst_cnt reaches BURST_LEN) or when src_almst_empty_i[grant]=1.
  - On exit, pointer := grant. This is the round-robin advance.
  - An idle grant cycle with the source already almost-empty exits with zero reads.
- Read path is registered: src_rd_o is a flop output. The grant decision cycle issues no read, so the first read appears 1 cycle after entering XFER.
- Write path:
  - dst_wr_o(t) = read_issued(t-RD_LATENCY).
  - dst_sel_o(t) = grant index at read time (t-RD_LATENCY), carried in a shift register beside the strobe.
  - Writes are never gated by dst_almst_full_i; the almost-full margin must cover RD_LATENCY+1 words.
  - Pipeline keeps draining across grant changes and IDLE. Back-to-back bursts from different sources are legal; dst_sel_o switches exactly on the first write of the new source.
- Simultaneous events:
  - Source goes almost-empty in the same cycle a read would be issued: no read.
  - burst_cnt==BURST_LEN-1 read cycle and source goes almost-empty: the read is suppressed only if the flag is already high at that edge.
- Counts are unsigned. burst_cnt is 8 bits wide.
- One-hot invariant: src_rd_o never has more than one bit set.

Optional Feature:
- Macro FIFO_ARB_XFER_CNT_EN.
- Defined: xfer_cnt_o increments on every dst_wr_o=1 cycle and saturates at 16'hFFFF (no wrap). Cleared only by reset.
- Undefined: counter logic omitted; xfer_cnt_o tied to 16'h0000. Port list unchanged.

Test Plan:
(All cases use N_SRC=4, RD_LATENCY=2, BURST_LEN=4 and the macro defined unless stated.)
- Reset release, all src_almst_empty_i=4'b1111 for 20 cycles -> src_rd_o=0, dst_wr_o=0, busy_o=0 throughout.
- Only src 2 non-empty, dst not full:
  - Expect grant_o=2 and exactly 4 src_rd_o=4'b0100 pulses on consecutive cycles.
  - 4 dst_wr_o pulses start 2 cycles after the first read, with dst_sel_o=2.
  - Return to IDLE; regrant to 2 follows.
- All 4 sources non-empty continuously -> grant order 0,1,2,3,0 with 4 reads each; xfer_cnt_o=16 after 4 bursts' writes complete.
- Src 1 granted; dst_almst_full_i high for 5 cycles after the 2nd read -> reads pause for 5 cycles, no regrant, then 2 more reads; total writes=4.
- Src 0 granted, src_almst_empty_i[0] rises after the 1st read -> burst ends with 1 read; next grant goes to src 1 if eligible.
- rst_ni pulled low during a burst with 2 writes in flight -> all outputs 0 asynchronously; no dst_wr_o after release until a new grant. With the macro undefined, xfer_cnt_o stays 0 in all cases.
